// File: rtl/mont_pkg.sv
// Shared types and helpers for the parametrised Montgomery multiplier.
package mont_pkg;

  typedef enum logic [1:0] {IDLE, ITER, REDUCE, DONE} state_t;

  localparam int DIGIT_BITS_MIN = 1;
  localparam int DIGIT_BITS_MAX = 2;

  // Quotient digit that clears the low digit of T: q = (-T * M^-1) mod 2^digit_bits.
  function automatic logic [1:0] q_digit(input logic [1:0] t_low, input logic [1:0] minv,
                                         input int digit_bits);
    logic [1:0] prod;
    prod = t_low * minv;
    prod = -prod;
    if (digit_bits == 1) prod[1] = 1'b0;
    return prod;
  endfunction

endpackage

// File: rtl/mont_digit_step.sv
// One combinational Montgomery iteration: C_next = (C + d*B + q*M) >> DIGIT_BITS.
module mont_digit_step
  import mont_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int DIGIT_BITS = 1
) (
  input  logic [WIDTH+1:0]      c_i,
  input  logic [DIGIT_BITS-1:0] d_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic [WIDTH-1:0]      m_i,
  input  logic [1:0]            minv_i,
  output logic [WIDTH+1:0]      c_o
);

  localparam int TW = WIDTH + DIGIT_BITS + 2;

  logic [TW-1:0] db, t, qm, s;
  logic [1:0]    q;
  logic          unused_low;

  // Digit products are built from shifted adds so no multiplier is inferred.
  always_comb begin
    db = '0;
    for (int i = 0; i < DIGIT_BITS; i++)
      if (d_i[i]) db = db + (TW'(b_i) << i);
    t = TW'(c_i) + db;
    q = q_digit(t[1:0], minv_i, DIGIT_BITS);
    qm = '0;
    for (int i = 0; i < DIGIT_BITS; i++)
      if (q[i]) qm = qm + (TW'(m_i) << i);
    s   = t + qm;
    c_o = s[TW-1:DIGIT_BITS];
  end

  assign unused_low = ^s[DIGIT_BITS-1:0];

endmodule

// File: rtl/montgomery_mult_param.sv
// Parametrised radix-2/radix-4 Montgomery multiplier with final conditional subtraction.
// Optional input checking is enabled by defining MONT_INPUT_CHECK_EN.
module montgomery_mult_param
  import mont_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int DIGIT_BITS = 1,
  parameter int CNT_W      = $clog2(WIDTH / DIGIT_BITS) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int N  = WIDTH / DIGIT_BITS;
  localparam int CW = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!(DIGIT_BITS == DIGIT_BITS_MIN || DIGIT_BITS == DIGIT_BITS_MAX)) begin : g_bad_digit
    $fatal(1, "montgomery_mult_param: DIGIT_BITS must be 1 or 2");
  end
  if (WIDTH % DIGIT_BITS != 0) begin : g_bad_width
    $fatal(1, "montgomery_mult_param: WIDTH must be a multiple of DIGIT_BITS");
  end
  if (WIDTH < 8) begin : g_small_width
    $fatal(1, "montgomery_mult_param: WIDTH must be at least 8");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
  logic [CW-1:0]     c_q, c_d, c_step;
  logic [1:0]        minv_q, minv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [CW-1:0] diff;
  logic              in_ok;
  logic              unused_diff;

`ifdef MONT_INPUT_CHECK_EN
  assign in_ok = in_m[0] && (in_a < in_m) && (in_b < in_m);
`else
  assign in_ok = 1'b1;
`endif

  mont_digit_step #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_step (
    .c_i    (c_q),
    .d_i    (a_q[DIGIT_BITS-1:0]),
    .b_i    (b_q),
    .m_i    (m_q),
    .minv_i (minv_q),
    .c_o    (c_step)
  );

  // C < 2M, so the sign of C - M in WIDTH+2 bits selects the reduced value.
  assign diff        = $signed(c_q) - $signed({2'b00, m_q});
  assign unused_diff = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    minv_d  = minv_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = in_a;
          b_d    = in_b;
          m_d    = in_m;
          minv_d = in_m[1:0];
          c_d    = '0;
          cnt_d  = '0;
          if (in_ok) begin
            state_d = ITER;
          end else begin
            res_d   = '0;
            state_d = DONE;
          end
        end
      end
      ITER: begin
        c_d   = c_step;
        a_d   = a_q >> DIGIT_BITS;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = REDUCE;
      end
      REDUCE: begin
        res_d   = diff[CW-1] ? c_q[WIDTH-1:0] : diff[WIDTH-1:0];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      c_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    m_q    <= m_d;
    minv_q <= minv_d;
  end

`ifdef MONT_INPUT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 1'b0;
    else if (state_q == IDLE && start) err_q <= !in_ok;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy   = (state_q == ITER) || (state_q == REDUCE);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Scoreboard bench: four multiplier instances (8/512 bits, radix-2/radix-4) checked against
// a modular-halving reference. Define MONT_INPUT_CHECK_EN to also cover input rejection.
module tb_montgomery_mult_param;

  typedef struct {
    int           idx;
    logic [511:0] res;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic [3:0]   start_v;
  logic [511:0] in_a, in_b, in_m;
  logic [3:0]   busy_v, done_v, err_v;
  logic [7:0]   r0, r1;
  logic [511:0] r2, r3;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  montgomery_mult_param #(.WIDTH(8), .DIGIT_BITS(1)) u0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_m(in_m[7:0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .result(r0));
  montgomery_mult_param #(.WIDTH(8), .DIGIT_BITS(2)) u1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_m(in_m[7:0]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .result(r1));
  montgomery_mult_param #(.WIDTH(512), .DIGIT_BITS(1)) u2 (
    .clk(clk), .resetn(resetn), .start(start_v[2]), .in_a(in_a), .in_b(in_b),
    .in_m(in_m), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .result(r2));
  montgomery_mult_param #(.WIDTH(512), .DIGIT_BITS(2)) u3 (
    .clk(clk), .resetn(resetn), .start(start_v[3]), .in_a(in_a), .in_b(in_b),
    .in_m(in_m), .busy(busy_v[3]), .done(done_v[3]), .err(err_v[3]), .result(r3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] res_of(input int idx);
    case (idx)
      0:       return {504'b0, r0};
      1:       return {504'b0, r1};
      2:       return r2;
      default: return r3;
    endcase
  endfunction

  function automatic int lat_of(input int idx);
    return ((idx < 2) ? 8 : 512) / ((idx % 2 == 1) ? 2 : 1) + 2;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // A*B mod M, then w modular halvings to divide by 2^w.
  function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m, input int w);
    logic [1023:0] p;
    logic [513:0]  x;
    p = {512'b0, a} * {512'b0, b};
    p = p % {512'b0, m};
    x = p[513:0];
    for (int i = 0; i < w; i++) begin
      if (x[0]) x = x + {2'b00, m};
      x = x >> 1;
    end
    return x[511:0];
  endfunction

  task automatic issue(input int idx, input logic [511:0] a, input logic [511:0] b,
                       input logic [511:0] m, input logic [511:0] er, input logic ee,
                       input int el);
    exp_t e;
    @(negedge clk);
    in_a = a; in_b = b; in_m = m;
    start_v = 4'b0;
    start_v[idx] = 1'b1;
    e.idx = idx; e.res = er; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    start_v = 4'b0;
    in_a = rnd512(); in_b = rnd512(); in_m = rnd512();
  endtask

  // Called right after issue(); lat counts from the accept edge to the edge sampling done.
  task automatic collect(input int idx, output int lat, output logic [511:0] res,
                         output logic e, output bit to);
    lat = 1;
    while (done_v[idx] !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    to  = (done_v[idx] !== 1'b1);
    res = res_of(idx);
    e   = err_v[idx];
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_v = 4'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({busy_v[i], done_v[i], err_v[i]} !== 3'b000 || res_of(i) !== 512'b0)
        $display("FAIL reset[%0d]: busy=%b done=%b err=%b result=%0h, want all zero",
                 i, busy_v[i], done_v[i], err_v[i], res_of(i));
      else n_pass++;
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] ta[4] = '{8'd5, 8'd238, 8'd1, 8'd0};
    logic [7:0] tb[4] = '{8'd7, 8'd238, 8'd17, 8'd200};
    logic [7:0] tr[4] = '{8'd227, 8'd225, 8'd1, 8'd0};
    int lat; logic [511:0] res; logic e; bit to; exp_t ex;
    for (int idx = 0; idx < 2; idx++) begin
      for (int k = 0; k < 4; k++) begin
        issue(idx, {504'b0, ta[k]}, {504'b0, tb[k]}, 512'd239, {504'b0, tr[k]}, 1'b0, lat_of(idx));
        collect(idx, lat, res, e, to);
        ex = sb.pop_front();
        n_checks++;
        if (to) $display("FAIL basic_timeout[%0d.%0d]: done never seen", idx, k);
        else n_pass++;
        n_checks++;
        if (lat !== ex.lat) $display("FAIL basic_latency[%0d.%0d]: got %0d want %0d", idx, k, lat, ex.lat);
        else n_pass++;
        n_checks++;
        if (res !== ex.res || e !== ex.err)
          $display("FAIL basic_result[%0d.%0d]: got %0d err %b want %0d err %b", idx, k, res, e, ex.res, ex.err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic [511:0] res; logic e; bit to; exp_t ex;
    issue(0, 512'd5, 512'd7, 512'd239, 512'd227, 1'b0, 10);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_v[0] !== 1'b1) $display("FAIL busy_mid_iter: got %b want 1", busy_v[0]);
    else n_pass++;
    in_a = 512'd1; in_b = 512'd17; in_m = 512'd239; start_v[0] = 1'b1;
    @(negedge clk);
    start_v = 4'b0;
    collect(0, lat, res, e, to);
    lat = lat + 3;
    ex = sb.pop_front();
    n_checks++;
    if (to || lat !== ex.lat) $display("FAIL ignore_latency: got %0d timeout %b want %0d", lat, to, ex.lat);
    else n_pass++;
    n_checks++;
    if (res !== ex.res) $display("FAIL ignore_result: got %0d want %0d", res, ex.res);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || r0 !== 8'd227)
      $display("FAIL hold_after_done: done=%b busy=%b result=%0d want 0 0 227", done_v[0], busy_v[0], r0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [511:0] res; logic e; bit to; exp_t ex; bit seen;
    issue(0, 512'd238, 512'd238, 512'd239, 512'd225, 1'b0, 10);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || r0 !== 8'd0)
      $display("FAIL reset_mid: busy=%b done=%b result=%0d want 0 0 0", busy_v[0], done_v[0], r0);
    else n_pass++;
    resetn = 1'b1;
    void'(sb.pop_front());
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL reset_abort_done: got done pulse want none");
    else n_pass++;
    issue(0, 512'd5, 512'd7, 512'd239, 512'd227, 1'b0, 10);
    collect(0, lat, res, e, to);
    ex = sb.pop_front();
    n_checks++;
    if (to || lat !== ex.lat || res !== ex.res)
      $display("FAIL rerun_after_reset: lat %0d res %0d want lat %0d res %0d", lat, res, ex.lat, ex.res);
    else n_pass++;
  endtask

`ifdef MONT_INPUT_CHECK_EN
  task automatic test_input_check();
    logic [511:0] va[4] = '{512'd5, 512'd240, 512'd5, 512'd5};
    logic [511:0] vb[4] = '{512'd7, 512'd7, 512'd239, 512'd7};
    logic [511:0] vm[4] = '{512'd238, 512'd239, 512'd239, 512'd239};
    int lat; logic [511:0] res; logic e; bit to; exp_t ex;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) issue(0, va[k], vb[k], vm[k], 512'd0, 1'b1, 1);
      else       issue(0, va[k], vb[k], vm[k], 512'd227, 1'b0, 10);
      collect(0, lat, res, e, to);
      ex = sb.pop_front();
      n_checks++;
      if (to || lat !== ex.lat) $display("FAIL check_latency[%0d]: got %0d want %0d", k, lat, ex.lat);
      else n_pass++;
      n_checks++;
      if (e !== ex.err || res !== ex.res)
        $display("FAIL check_result[%0d]: err %b res %0d want err %b res %0d", k, e, res, ex.err, ex.res);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    int lat; logic [511:0] res; logic e; bit to; exp_t ex;
    logic [511:0] a, b, m;
    int idx, w;
    for (int k = 0; k < 12; k++) begin
      idx = k % 4;
      w = (idx < 2) ? 8 : 512;
      if (w == 8) m = 512'($urandom_range(128, 255) | 1);
      else begin
        m = rnd512();
        m[511] = 1'b1;
        m[0] = 1'b1;
      end
      a = (k >= 8) ? m - 512'd1 : rnd512() % m;
      b = rnd512() % m;
      issue(idx, a, b, m, mont_ref(a, b, m, w), 1'b0, lat_of(idx));
      collect(idx, lat, res, e, to);
      ex = sb.pop_front();
      n_checks++;
      if (to || lat !== ex.lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, ex.lat);
      else n_pass++;
      n_checks++;
      if (res !== ex.res || e !== ex.err)
        $display("FAIL rand_result[%0d]: got %0h err %b want %0h err %b", k, res, e, ex.res, ex.err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
`ifdef MONT_INPUT_CHECK_EN
    test_input_check();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
